// File: rtl/field_packer.sv
// field_packer: gathers up to four 3-bit fields and emits one 16-bit word per field, flushing partial groups after an idle timeout
module field_packer #(
  parameter int FLUSH_TIMEOUT = 8,
  parameter int TO_W = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [2:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [15:0] o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_busy
);
  typedef enum logic {FILL, SEND} state_t;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FLUSH_TIMEOUT - 1);
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d, sel_q, sel_d, last_q, last_d;
  logic [3:0][2:0] f_q, f_d;
  logic [TO_W-1:0] idle_q, idle_d;
  logic flushed_q, flushed_d;
  logic [15:0] data_q, data_d;
  logic accept;
  function automatic logic [15:0] pack(input logic [3:0][2:0] f, input logic [1:0] s,
                                       input logic last, input logic fl);
    return {last, fl, f[3], f[2], f[1], f[0], s};
  endfunction
  assign o_ready = state_q == FILL;
  assign o_valid = state_q == SEND;
  assign o_data  = data_q;
  assign o_busy  = state_q != FILL || cnt_q != 2'd0;
  assign accept  = i_valid & o_ready;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    last_d    = last_q;
    f_d       = f_q;
    idle_d    = idle_q;
    flushed_d = flushed_q;
    data_d    = data_q;
    if (state_q == FILL) begin
      if (accept) begin
        f_d[cnt_q] = i_data;
        cnt_d      = cnt_q + 2'd1;
        idle_d     = '0;
        if (cnt_q == 2'd3) begin
          state_d   = SEND;
          sel_d     = 2'd0;
          last_d    = 2'd3;
          flushed_d = 1'b0;
          data_d    = pack(f_d, 2'd0, 1'b0, 1'b0);
        end
      end else if (cnt_q == 2'd0) begin
        idle_d = '0;
      end else if (FLUSH_TIMEOUT != 0 && idle_q == TO_LAST) begin
        // partial group: word count equals fields collected so far
        state_d   = SEND;
        sel_d     = 2'd0;
        last_d    = cnt_q - 2'd1;
        flushed_d = 1'b1;
        idle_d    = '0;
        data_d    = pack(f_d, 2'd0, cnt_q == 2'd1, 1'b1);
      end else begin
        idle_d = idle_q + TO_W'(1);
      end
    end else if (i_ready) begin
      if (sel_q == last_q) begin
        state_d = FILL;
        cnt_d   = 2'd0;
        sel_d   = 2'd0;
        f_d     = '0;
        idle_d  = '0;
        data_d  = 16'h0000;
      end else begin
        sel_d  = sel_q + 2'd1;
        data_d = pack(f_q, sel_d, sel_d == last_q, flushed_q);
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= FILL;
      cnt_q     <= 2'd0;
      sel_q     <= 2'd0;
      last_q    <= 2'd0;
      f_q       <= '0;
      idle_q    <= '0;
      flushed_q <= 1'b0;
      data_q    <= 16'h0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      f_q       <= f_d;
      idle_q    <= idle_d;
      flushed_q <= flushed_d;
      data_q    <= data_d;
    end
  end
endmodule

// File: tb/tb_field_packer.sv
// tb_field_packer: table vectors, directed corner sequences and a queue-based reference model for field_packer
module tb_field_packer;
  localparam int FT = 8;
  logic i_clk = 1'b0, i_rst_n, i_valid, i_ready, o_ready, o_valid, o_busy;
  logic [2:0] i_data;
  logic [15:0] o_data;
  int checks = 0, errors = 0;
  int grp[$];
  logic [15:0] outq[$];
  int idle = 0;
  typedef struct {
    logic r, v;
    logic [2:0] d;
    logic rdy, ev, er, eb, cd;
    logic [15:0] ed;
  } vec_t;
  vec_t tbl[10];

  field_packer #(.FLUSH_TIMEOUT(FT), .TO_W(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endtask

  task automatic emit(input bit fl);
    int n;
    logic [15:0] base;
    n = grp.size();
    base = 16'h0000;
    for (int j = 0; j < n; j++) base = base | (16'(grp[j]) << (3 * j + 2));
    for (int k = 0; k < n; k++)
      outq.push_back(base | (fl ? 16'h4000 : 16'h0000) | (k == n - 1 ? 16'h8000 : 16'h0000) | 16'(k));
    grp.delete();
    idle = 0;
  endtask

  task automatic model_step();
    if (!i_rst_n) begin
      grp.delete();
      outq.delete();
      idle = 0;
    end else if (outq.size() != 0) begin
      if (i_ready) void'(outq.pop_front());
    end else if (i_valid) begin
      grp.push_back(int'(i_data));
      idle = 0;
      if (grp.size() == 4) emit(1'b0);
    end else if (grp.size() == 0) idle = 0;
    else if (FT != 0 && idle == FT - 1) emit(1'b1);
    else idle++;
  endtask

  task automatic check_model();
    chk("m_valid", 16'(o_valid), 16'(outq.size() != 0));
    chk("m_ready", 16'(o_ready), 16'(outq.size() == 0));
    chk("m_busy", 16'(o_busy), 16'(outq.size() != 0 || grp.size() != 0));
    if (outq.size() != 0) chk("m_data", o_data, outq[0]);
  endtask

  task automatic step(input logic r, input logic v, input logic [2:0] d, input logic rdy);
    i_rst_n = r;
    i_valid = v;
    i_data = d;
    i_ready = rdy;
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
    check_model();
  endtask

  task automatic fields(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c, input logic [2:0] e);
    step(1, 1, a, 1);
    step(1, 1, b, 1);
    step(1, 1, c, 1);
    step(1, 1, e, 1);
  endtask

  initial begin
    int n, dens;
    tbl[0] = '{0, 0, 0, 1, 0, 1, 0, 1, 16'h0000};
    tbl[1] = '{0, 0, 0, 1, 0, 1, 0, 1, 16'h0000};
    tbl[2] = '{1, 1, 5, 1, 0, 1, 1, 0, 16'h0000};
    tbl[3] = '{1, 1, 3, 1, 0, 1, 1, 0, 16'h0000};
    tbl[4] = '{1, 1, 7, 1, 0, 1, 1, 0, 16'h0000};
    tbl[5] = '{1, 1, 1, 1, 1, 0, 1, 1, 16'h0F74};
    tbl[6] = '{1, 0, 0, 1, 1, 0, 1, 1, 16'h0F75};
    tbl[7] = '{1, 0, 0, 1, 1, 0, 1, 1, 16'h0F76};
    tbl[8] = '{1, 0, 0, 1, 1, 0, 1, 1, 16'h8F77};
    tbl[9] = '{1, 0, 0, 1, 0, 1, 0, 0, 16'h0000};
    @(negedge i_clk);
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].rdy);
      chk($sformatf("t%0d_valid", i), 16'(o_valid), 16'(tbl[i].ev));
      chk($sformatf("t%0d_ready", i), 16'(o_ready), 16'(tbl[i].er));
      chk($sformatf("t%0d_busy", i), 16'(o_busy), 16'(tbl[i].eb));
      if (tbl[i].cd) chk($sformatf("t%0d_data", i), o_data, tbl[i].ed);
    end
    // backpressure at sel=1
    fields(5, 3, 7, 1);
    step(1, 1, 6, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 6, 0);
      chk("bp_hold", o_data, 16'h0F75);
      chk("bp_ready", 16'(o_ready), 16'h0000);
    end
    step(1, 0, 0, 1);
    chk("bp_resume", o_data, 16'h0F76);
    step(1, 0, 0, 1);
    chk("bp_last", o_data, 16'h8F77);
    step(1, 0, 0, 1);
    // flush of a two-field group
    step(1, 1, 6, 1);
    step(1, 1, 2, 1);
    n = 0;
    while (!o_valid && n < 20) begin
      step(1, 0, 0, 1);
      n++;
    end
    chk("flush_lat", 16'(n), 16'd8);
    chk("flush_w0", o_data, 16'h4058);
    step(1, 0, 0, 1);
    chk("flush_w1", o_data, 16'hC059);
    step(1, 0, 0, 1);
    chk("flush_ready", 16'(o_ready), 16'h0001);
    // accept on the timeout cycle beats the flush
    step(1, 1, 1, 1);
    step(1, 1, 2, 1);
    step(1, 1, 3, 1);
    for (int i = 0; i < FT - 1; i++) step(1, 0, 0, 1);
    step(1, 1, 4, 1);
    chk("race_w0", o_data, 16'h2344);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
    chk("race_w3", o_data, 16'hA347);
    step(1, 0, 0, 1);
    // reset while sending sel=2
    fields(7, 7, 7, 7);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(0, 1, 5, 1);
    chk("rst_valid", 16'(o_valid), 16'h0000);
    chk("rst_ready", 16'(o_ready), 16'h0001);
    chk("rst_busy", 16'(o_busy), 16'h0000);
    fields(2, 4, 6, 0);
    chk("rst_new", o_data, 16'h0688);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
    // randomized traffic with varying field density
    dens = 5;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) dens = int'($urandom_range(0, 9));
      step(($urandom_range(0, 499) != 0), ($urandom_range(0, 9) < dens),
           3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
